// File: rtl/playback_sequencer.sv
// playback_sequencer: reads song words from the note memory one at a time and
// holds each word on the tone generator inputs for a fixed duration, with a
// silent gap between notes. Supports pause, stop, looping and end detection.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; outputs silent
// REWIND | mem_rd_rst high for one cycle to rewind the read pointer
// FETCH  | mem_rd_en high for one cycle; timeout counter cleared
// WAIT   | waiting for mem_ready; end marker -> DONE, timeout -> IDLE
// PLAY   | current word driven on notes/shift for NOTE_CYCLES
// GAP    | silence for GAP_CYCLES, then advance to the next word
// DONE   | done pulse; restart if loop, else IDLE
module playback_sequencer #(
  parameter int DATA_WIDTH     = 10,
  parameter int NOTE_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 2_500_000,
  parameter int MAX_NOTES      = 64,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IDX_W         = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  loop,
  output logic                  mem_rd_rst,
  output logic                  mem_rd_en,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [7:0]            notes,
  output logic [1:0]            shift,
  output logic [7:0]            leds,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      note_idx
);

  // One counter times both the note and the gap, so it is sized for the longer.
  localparam int DUR_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(MAX_NOTES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REWIND = 3'd1,
    FETCH  = 3'd2,
    WAIT   = 3'd3,
    PLAY   = 3'd4,
    GAP    = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t            state_q, state_n;
  logic [DUR_W-1:0]  dur_q, dur_n;
  logic [TO_W-1:0]   to_q, to_n;
  logic [7:0]        hold_notes_q, hold_notes_n;
  logic [1:0]        hold_shift_q, hold_shift_n;
  logic [IDX_W-1:0]  idx_n;
  logic              error_n;
  logic [7:0]        notes_n;
  logic [1:0]        shift_n;
  logic              busy_n;
  logic              done_n;
  logic              rd_rst_n;
  logic              rd_en_n;

  // The word in memory is packed as {notes, shift}; shift==2'b11 marks song end.
  logic [7:0] word_notes;
  logic [1:0] word_shift;
  assign word_notes = mem_data[9:2];
  assign word_shift = mem_data[1:0];

  assign leds = notes;

  // Next-state logic plus the next value of every registered output.
  always_comb begin
    state_n      = state_q;
    dur_n        = dur_q;
    to_n         = to_q;
    hold_notes_n = hold_notes_q;
    hold_shift_n = hold_shift_q;
    idx_n        = note_idx;
    error_n      = error;

    if (stop) begin
      state_n      = IDLE;
      dur_n        = '0;
      to_n         = '0;
      hold_notes_n = '0;
      hold_shift_n = '0;
      idx_n        = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_n = REWIND;
            error_n = 1'b0;
            idx_n   = '0;
          end
        end
        REWIND: state_n = FETCH;
        FETCH: begin
          state_n = WAIT;
          to_n    = '0;
        end
        WAIT: begin
          if (mem_ready) begin
            if (word_shift == 2'b11) begin
              state_n = DONE;
            end else begin
              hold_notes_n = word_notes;
              hold_shift_n = word_shift;
              dur_n        = '0;
              state_n      = PLAY;
            end
          end else if (to_q == TO_LAST) begin
            error_n = 1'b1;
            state_n = IDLE;
          end else begin
            to_n = to_q + TO_W'(1);
          end
        end
        PLAY: begin
          if (!pause) begin
            if (dur_q == NOTE_LAST) begin
              dur_n        = '0;
              hold_notes_n = '0;
              hold_shift_n = '0;
              state_n      = GAP;
            end else begin
              dur_n = dur_q + DUR_W'(1);
            end
          end
        end
        GAP: begin
          if (!pause) begin
            if (dur_q == GAP_LAST) begin
              dur_n = '0;
              // Last slot: the index stays on the final word rather than wrapping.
              if (note_idx == IDX_LAST) begin
                state_n = DONE;
              end else begin
                idx_n   = note_idx + IDX_W'(1);
                state_n = FETCH;
              end
            end else begin
              dur_n = dur_q + DUR_W'(1);
            end
          end
        end
        DONE: begin
          if (loop) begin
            state_n = REWIND;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Outputs are registered from the next state, so each strobe lines up with
    // the cycle spent in its state. REWIND and FETCH each last one cycle, which
    // gives one pulse per entry and keeps the two strobes mutually exclusive.
    rd_rst_n = (state_n == REWIND);
    rd_en_n  = (state_n == FETCH);
    done_n   = (state_n == DONE);
    busy_n   = (state_n != IDLE);
    notes_n  = '0;
    shift_n  = '0;
    if (state_n == PLAY && !pause) begin
      notes_n = hold_notes_n;
      shift_n = hold_shift_n;
    end
  end

  // State, counters and all outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dur_q        <= '0;
      to_q         <= '0;
      hold_notes_q <= '0;
      hold_shift_q <= '0;
      note_idx     <= '0;
      error        <= 1'b0;
      notes        <= '0;
      shift        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_rd_rst   <= 1'b0;
      mem_rd_en    <= 1'b0;
    end else begin
      state_q      <= state_n;
      dur_q        <= dur_n;
      to_q         <= to_n;
      hold_notes_q <= hold_notes_n;
      hold_shift_q <= hold_shift_n;
      note_idx     <= idx_n;
      error        <= error_n;
      notes        <= notes_n;
      shift        <= shift_n;
      busy         <= busy_n;
      done         <= done_n;
      mem_rd_rst   <= rd_rst_n;
      mem_rd_en    <= rd_en_n;
    end
  end

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench for playback_sequencer with short note/gap timing and a
// one-cycle-latency memory model.
module tb_playback_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loop = 1'b0;
  logic       mem_rd_rst;
  logic       mem_rd_en;
  logic       mem_ready;
  logic [9:0] mem_data;
  logic [7:0] notes;
  logic [1:0] shift;
  logic [7:0] leds;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] note_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rd = 0;
  int n_rst = 0;
  int n_done = 0;
  int n_both = 0;
  int rd0, rs0, dn0;

  logic [9:0] mem [0:7];
  logic [2:0] addr;
  logic       mem_ok = 1'b1;

  playback_sequencer #(
    .DATA_WIDTH(10),
    .NOTE_CYCLES(4),
    .GAP_CYCLES(2),
    .MAX_NOTES(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .pause(pause),
    .loop(loop),
    .mem_rd_rst(mem_rd_rst),
    .mem_rd_en(mem_rd_en),
    .mem_ready(mem_ready),
    .mem_data(mem_data),
    .notes(notes),
    .shift(shift),
    .leds(leds),
    .busy(busy),
    .done(done),
    .error(error),
    .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  // Memory: answers one cycle after a read request when mem_ok is set.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      mem_ready <= 1'b0;
      mem_data  <= '0;
    end else begin
      mem_ready <= mem_rd_en && mem_ok;
      mem_data  <= mem[addr];
      if (mem_rd_rst) addr <= '0;
      else if (mem_rd_en) addr <= addr + 3'd1;
    end
  end

  // Strobe counters.
  always @(posedge clk) begin
    if (mem_rd_en) n_rd++;
    if (mem_rd_rst) n_rst++;
    if (done) n_done++;
    if (mem_rd_en && mem_rd_rst) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plays a song from a start pulse. Each word k occupies FETCH, WAIT, 4 PLAY,
  // 2 GAP cycles, so word k sounds at cycles 4+8k .. 7+8k after the start edge.
  task automatic run_song(input int n_cyc, input int n_words, input int done_at);
    logic [9:0] exp_word;
    int k, idx;
    start = 1'b1;
    for (int i = 1; i <= n_cyc; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      exp_word = '0;
      if (i >= 4) begin
        k = (i - 4) / 8;
        if (((i - 4) % 8) < 4 && k < n_words) exp_word = mem[k];
      end
      idx = (i < 2) ? 0 : (i - 2) / 8;
      if (idx > 3) idx = 3;
      check("song_notes_shift", 32'({notes, shift}), 32'(exp_word));
      check("song_leds", 32'(leds), 32'(exp_word[9:2]));
      check("song_done", 32'(done), 32'(i == done_at));
      check("song_busy", 32'(busy), 32'(i <= done_at));
      check("song_idx", 32'(note_idx), 32'(idx));
      check("song_rd_en", 32'(mem_rd_en), 32'(i >= 2 && ((i - 2) % 8) == 0 && i < done_at));
      check("song_rd_rst", 32'(mem_rd_rst), 32'(i == 1));
    end
  endtask

  initial begin
    for (int j = 0; j < 8; j++) mem[j] = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_notes", 32'(notes), 32'h0);
    check("rst_shift", 32'(shift), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_idx", 32'(note_idx), 32'h0);
    check("rst_rd_en", 32'(mem_rd_en), 32'h0);
    check("rst_rd_rst", 32'(mem_rd_rst), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic playback: two notes then an end marker
    mem[0] = 10'h006;
    mem[1] = 10'h009;
    mem[2] = 10'h003;
    rd0 = n_rd;
    rs0 = n_rst;
    run_song(21, 2, 20);
    check("basic_reads", 32'(n_rd - rd0), 32'd3);
    check("basic_rewinds", 32'(n_rst - rs0), 32'd1);

    // MAX_NOTES limit: four words, no marker, a fifth word that must not be read
    mem[0] = 10'h005;
    mem[1] = 10'h00A;
    mem[2] = 10'h010;
    mem[3] = 10'h021;
    mem[4] = 10'h041;
    rd0 = n_rd;
    rs0 = n_rst;
    run_song(35, 4, 34);
    check("max_reads", 32'(n_rd - rd0), 32'd4);
    check("max_rewinds", 32'(n_rst - rs0), 32'd1);

    // Pause for 5 cycles starting in the second PLAY cycle
    mem[0] = 10'h006;
    mem[1] = 10'h003;
    start = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      check("pause_notes_shift", 32'({notes, shift}),
            (i == 4 || i == 5 || i == 11 || i == 12) ? 32'h006 : 32'h0);
      check("pause_done", 32'(done), 32'(i == 17));
      check("pause_busy", 32'(busy), 32'(i <= 17));
      if (i == 5) pause = 1'b1;
      if (i == 10) pause = 1'b0;
    end

    // Timeout: memory never answers
    mem_ok = 1'b0;
    dn0 = n_done;
    start = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 10) check("to_error_before", 32'(error), 32'h0);
      if (i == 10) check("to_busy_before", 32'(busy), 32'h1);
      if (i == 11) check("to_error_set", 32'(error), 32'h1);
      if (i == 11) check("to_busy_after", 32'(busy), 32'h0);
    end
    @(negedge clk);
    check("to_no_done", 32'(n_done - dn0), 32'd0);
    check("to_error_sticky", 32'(error), 32'h1);

    // Restart clears error; stop coincides with mem_ready in WAIT
    mem_ok = 1'b1;
    mem[0] = 10'h006;
    mem[1] = 10'h003;
    start = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 1) check("restart_error_clr", 32'(error), 32'h0);
      if (i == 1) check("restart_busy", 32'(busy), 32'h1);
      if (i == 3) check("stop_mem_ready", 32'(mem_ready), 32'h1);
      if (i == 4) stop = 1'b0;
      if (i >= 4) begin
        check("stop_busy", 32'(busy), 32'h0);
        check("stop_notes_shift", 32'({notes, shift}), 32'h0);
        check("stop_idx", 32'(note_idx), 32'h0);
      end
      if (i == 3) stop = 1'b1;
    end

    // Loop: end marker with loop=1 rewinds and plays again
    loop = 1'b1;
    rs0 = n_rst;
    start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 12) check("loop_done", 32'(done), 32'h1);
      if (i == 13) begin
        check("loop_rd_rst", 32'(mem_rd_rst), 32'h1);
        check("loop_busy", 32'(busy), 32'h1);
        check("loop_idx", 32'(note_idx), 32'h0);
        loop = 1'b0;
      end
      if (i == 16) check("loop_replay", 32'({notes, shift}), 32'h006);
    end
    check("loop_rewinds", 32'(n_rst - rs0), 32'd2);

    // Reset mid-PLAY clears outputs without waiting for a clock edge
    rst = 1'b1;
    #1;
    check("arst_notes", 32'(notes), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_idx", 32'(note_idx), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_idle", 32'(busy), 32'h0);
    check("strobe_overlap", 32'(n_both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
